// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU Memory stage vs. image DMA bursts.
// Optional starvation guard compiled in with MEMARB_STARVE_GUARD_EN.
module data_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BURST_MAX  = 16,
  parameter int STARVE_LIM = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_rvalid,
  output logic                      mem_stall,
  input  logic                      dma_req,
  input  logic                      dma_we,
  input  logic [ADDR_W-1:0]         dma_addr,
  input  logic [$clog2(BURST_MAX):0] dma_len,
  output logic                      dma_gnt,
  input  logic [DATA_W-1:0]         dma_wdata,
  output logic                      dma_wready,
  output logic [DATA_W-1:0]         dma_rdata,
  output logic                      dma_rvalid,
  output logic                      dma_done,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int LW = $clog2(BURST_MAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              dir_q, dir_d;
  logic [LW-1:0]     rem_q, rem_d;
  logic [LW-1:0]     beat_q, beat_d;
  logic [LW-1:0]     len_c;
  logic              cpu_rv_q, cpu_rv_d;
  logic              dma_rv_q, dma_rv_d;
  logic              done_q, done_d;
  logic              forced;
  logic              grant;

  always_comb begin
    len_c = dma_len;
    if (dma_len == '0)
      len_c = LW'(1);
    else if (dma_len > LW'(BURST_MAX))
      len_c = LW'(BURST_MAX);
  end

  assign grant = (state_q != S_DMA) &&
                 (forced || (dma_req && !cpu_req));

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int WW = $clog2(STARVE_LIM + 1);

  logic [WW-1:0] starve_q, starve_d;

  assign forced = dma_req && (starve_q == WW'(STARVE_LIM));

  always_comb begin
    starve_d = starve_q;
    if (grant)
      starve_d = '0;
    else if (dma_req && (starve_q != WW'(STARVE_LIM)))
      starve_d = starve_q + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    dir_d      = dir_q;
    rem_d      = rem_q;
    beat_d     = beat_q;
    cpu_rv_d   = 1'b0;
    dma_rv_d   = 1'b0;
    done_d     = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_stall  = 1'b0;
    dma_gnt    = 1'b0;
    dma_wready = 1'b0;
    dma_done   = done_q;
    cpu_rvalid = cpu_rv_q;
    cpu_rdata  = cpu_rv_q ? mem_rdata : '0;
    dma_rvalid = dma_rv_q;
    dma_rdata  = dma_rv_q ? mem_rdata : '0;
    unique case (state_q)
      S_IDLE, S_CPU: begin
        if (grant) begin
          dma_gnt   = 1'b1;
          mem_stall = cpu_req;
          base_d    = dma_addr;
          dir_d     = dma_we;
          rem_d     = len_c;
          beat_d    = '0;
          state_d   = S_DMA;
        end else if (cpu_req) begin
          mem_addr  = cpu_addr;
          mem_we    = cpu_we;
          mem_wdata = cpu_wdata;
          cpu_rv_d  = !cpu_we;
          state_d   = S_CPU;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_DMA: begin
        mem_addr  = base_q + ADDR_W'({beat_q, 2'b00});
        mem_we    = dir_q;
        mem_stall = cpu_req;
        if (dir_q) begin
          mem_wdata  = dma_wdata;
          dma_wready = 1'b1;
        end else begin
          dma_rv_d   = 1'b1;
        end
        beat_d = beat_q + LW'(1);
        rem_d  = rem_q - LW'(1);
        // last beat: writes finish now, reads finish with their data
        if (rem_q == LW'(1)) begin
          state_d = S_IDLE;
          beat_d  = '0;
          if (dir_q) dma_done = 1'b1;
          else       done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      mem_stall  = 1'b0;
      dma_gnt    = 1'b0;
      dma_wready = 1'b0;
      dma_done   = 1'b0;
      cpu_rvalid = 1'b0;
      cpu_rdata  = '0;
      dma_rvalid = 1'b0;
      dma_rdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      dir_q    <= 1'b0;
      rem_q    <= '0;
      beat_q   <= '0;
      cpu_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      beat_q   <= beat_d;
      cpu_rv_q <= cpu_rv_d;
      dma_rv_q <= dma_rv_d;
      done_q   <= done_d;
    end
  end

endmodule
